// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched ALU ops, snoops both result buses, issues the lowest-index ready entry.
// Optional macro ALU_RS_WAKEUP_BYPASS_EN: a CDB wakeup may issue in the same cycle with the broadcast value bypassed.
module alu_reservation_station #(
  parameter int RS_SIZE       = 8,
  parameter int TYPE_BIT      = 6,
  parameter int ROB_INDEX_BIT = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear_in,
  input  logic                     disp_valid,
  input  logic [TYPE_BIT-1:0]      disp_type,
  input  logic [ROB_INDEX_BIT-1:0] disp_rob_id,
  input  logic [31:0]              disp_vj,
  input  logic [31:0]              disp_vk,
  input  logic                     disp_qj_busy,
  input  logic                     disp_qk_busy,
  input  logic [ROB_INDEX_BIT-1:0] disp_qj,
  input  logic [ROB_INDEX_BIT-1:0] disp_qk,
  output logic                     full,
  input  logic                     alu_cdb_valid,
  input  logic [ROB_INDEX_BIT-1:0] alu_cdb_rob_id,
  input  logic [31:0]              alu_cdb_value,
  input  logic                     lsb_cdb_valid,
  input  logic [ROB_INDEX_BIT-1:0] lsb_cdb_rob_id,
  input  logic [31:0]              lsb_cdb_value,
  output logic                     alu_req,
  output logic [TYPE_BIT-1:0]      alu_type,
  output logic [31:0]              alu_r1,
  output logic [31:0]              alu_r2,
  output logic [ROB_INDEX_BIT-1:0] alu_rob_id
);
  localparam int IDX_BIT = $clog2(RS_SIZE);

  typedef struct packed {
    logic                     busy;
    logic [TYPE_BIT-1:0]      op;
    logic [ROB_INDEX_BIT-1:0] rob_id;
    logic [31:0]              vj;
    logic [31:0]              vk;
    logic                     qj_busy;
    logic [ROB_INDEX_BIT-1:0] qj;
    logic                     qk_busy;
    logic [ROB_INDEX_BIT-1:0] qk;
  } entry_t;

  entry_t             ent_q [RS_SIZE];
  entry_t             ent_d [RS_SIZE];
  logic               full_d;
  logic               issue_hit;
  logic               free_hit;
  logic [IDX_BIT-1:0] issue_idx;
  logic [IDX_BIT-1:0] free_idx;
  logic [31:0]        issue_r1;
  logic [31:0]        issue_r2;

  function automatic logic cdb_hit(input logic [ROB_INDEX_BIT-1:0] tag);
    return (alu_cdb_valid && alu_cdb_rob_id == tag) || (lsb_cdb_valid && lsb_cdb_rob_id == tag);
  endfunction

  // ALU bus wins when both buses carry the same tag.
  function automatic logic [31:0] cdb_value(input logic [ROB_INDEX_BIT-1:0] tag);
    return (alu_cdb_valid && alu_cdb_rob_id == tag) ? alu_cdb_value : lsb_cdb_value;
  endfunction

  // Issue and free-slot selection, both lowest index first, from registered occupancy.
  always_comb begin
    logic j_ok;
    logic k_ok;
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    j_ok      = 1'b0;
    k_ok      = 1'b0;
    issue_hit = 1'b0;
    issue_idx = '0;
    issue_r1  = '0;
    issue_r2  = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
`ifdef ALU_RS_WAKEUP_BYPASS_EN
      j_ok = !ent_q[i].qj_busy || cdb_hit(ent_q[i].qj);
      k_ok = !ent_q[i].qk_busy || cdb_hit(ent_q[i].qk);
`else
      j_ok = !ent_q[i].qj_busy;
      k_ok = !ent_q[i].qk_busy;
`endif
      if (!issue_hit && ent_q[i].busy && j_ok && k_ok) begin
        issue_hit = 1'b1;
        issue_idx = IDX_BIT'(i);
        issue_r1  = ent_q[i].qj_busy ? cdb_value(ent_q[i].qj) : ent_q[i].vj;
        issue_r2  = ent_q[i].qk_busy ? cdb_value(ent_q[i].qk) : ent_q[i].vk;
      end
      if (!free_hit && !ent_q[i].busy) begin
        free_hit = 1'b1;
        free_idx = IDX_BIT'(i);
      end
    end
  end

  // Next-state: wakeup, free the issued slot, then dispatch into the pre-edge free slot.
  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ent_q[i].busy && ent_q[i].qj_busy && cdb_hit(ent_q[i].qj)) begin
        ent_d[i].qj_busy = 1'b0;
        ent_d[i].vj      = cdb_value(ent_q[i].qj);
      end
      if (ent_q[i].busy && ent_q[i].qk_busy && cdb_hit(ent_q[i].qk)) begin
        ent_d[i].qk_busy = 1'b0;
        ent_d[i].vk      = cdb_value(ent_q[i].qk);
      end
    end
    if (issue_hit) ent_d[issue_idx].busy = 1'b0;
    if (disp_valid && !full && free_hit) begin
      ent_d[free_idx].busy    = 1'b1;
      ent_d[free_idx].op      = disp_type;
      ent_d[free_idx].rob_id  = disp_rob_id;
      ent_d[free_idx].qj      = disp_qj;
      ent_d[free_idx].qk      = disp_qk;
      ent_d[free_idx].qj_busy = disp_qj_busy && !cdb_hit(disp_qj);
      ent_d[free_idx].qk_busy = disp_qk_busy && !cdb_hit(disp_qk);
      ent_d[free_idx].vj      = (disp_qj_busy && cdb_hit(disp_qj)) ? cdb_value(disp_qj) : disp_vj;
      ent_d[free_idx].vk      = (disp_qk_busy && cdb_hit(disp_qk)) ? cdb_value(disp_qk) : disp_vk;
    end
    full_d = 1'b1;
    for (int i = 0; i < RS_SIZE; i++) full_d = full_d && ent_d[i].busy;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      // NOTE: only the busy flags are reset; payload fields are never read while their entry is free.
      for (int i = 0; i < RS_SIZE; i++) ent_q[i].busy <= 1'b0;
      alu_req    <= 1'b0;
      alu_type   <= '0;
      alu_r1     <= '0;
      alu_r2     <= '0;
      alu_rob_id <= '0;
      full       <= 1'b0;
    end else if (clear_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i].busy <= 1'b0;
      alu_req <= 1'b0;
      full    <= 1'b0;
    end else if (rdy_in) begin
      ent_q   <= ent_d;
      full    <= full_d;
      alu_req <= issue_hit;
      if (issue_hit) begin
        alu_type   <= ent_q[issue_idx].op;
        alu_r1     <= issue_r1;
        alu_r2     <= issue_r2;
        alu_rob_id <= ent_q[issue_idx].rob_id;
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios plus a randomized run against a behavioural model.
// Handles both builds of ALU_RS_WAKEUP_BYPASS_EN.
module tb_alu_reservation_station;
  localparam int RS_SIZE = 8;
  localparam int TB      = 6;
  localparam int RB      = 4;
  localparam int VEC_W   = 1 + TB + 32 + 32 + RB + 1;
`ifdef ALU_RS_WAKEUP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam int WAKE_LAT = BYPASS ? 0 : 1;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, clear_in, disp_valid, disp_qj_busy, disp_qk_busy;
  logic [TB-1:0] disp_type;
  logic [RB-1:0] disp_rob_id, disp_qj, disp_qk, alu_cdb_rob_id, lsb_cdb_rob_id;
  logic [31:0]   disp_vj, disp_vk, alu_cdb_value, lsb_cdb_value;
  logic          alu_cdb_valid, lsb_cdb_valid;
  logic          full, alu_req;
  logic [TB-1:0] alu_type;
  logic [31:0]   alu_r1, alu_r2;
  logic [RB-1:0] alu_rob_id;

  always #5 clk_in = ~clk_in;

  alu_reservation_station #(.RS_SIZE(RS_SIZE), .TYPE_BIT(TB), .ROB_INDEX_BIT(RB)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .disp_valid(disp_valid), .disp_type(disp_type), .disp_rob_id(disp_rob_id),
    .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_qj_busy(disp_qj_busy), .disp_qk_busy(disp_qk_busy),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .full(full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_id(alu_cdb_rob_id), .alu_cdb_value(alu_cdb_value),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_value(lsb_cdb_value),
    .alu_req(alu_req), .alu_type(alu_type), .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_rob_id(alu_rob_id)
  );

  wire [VEC_W-1:0] dut_vec = {alu_req, alu_type, alu_r1, alu_r2, alu_rob_id, full};

  // Behavioural model: slots in index order, each holding an op and its two operands.
  typedef struct {
    logic          busy;
    logic [TB-1:0] op;
    logic [RB-1:0] rob;
    logic [31:0]   vj, vk;
    logic          jw, kw;
    logic [RB-1:0] qj, qk;
  } m_ent_t;

  m_ent_t        m [RS_SIZE];
  logic          m_req, m_full;
  logic [TB-1:0] m_type;
  logic [31:0]   m_r1, m_r2;
  logic [RB-1:0] m_rob;
  int            checks = 0;
  int            passed = 0;

  function automatic logic [VEC_W-1:0] m_vec();
    return {m_req, m_type, m_r1, m_r2, m_rob, m_full};
  endfunction

  function automatic void lookup(input logic [RB-1:0] tag, output bit hit, output logic [31:0] val);
    hit = 1'b0;
    val = '0;
    if (lsb_cdb_valid && lsb_cdb_rob_id == tag) begin hit = 1'b1; val = lsb_cdb_value; end
    if (alu_cdb_valid && alu_cdb_rob_id == tag) begin hit = 1'b1; val = alu_cdb_value; end
  endfunction

  task automatic model_step();
    int          sel, free_slot;
    bit          jh, kh, jr, kr;
    logic [31:0] jv, kv;
    if (rst_in) begin
      foreach (m[i]) m[i].busy = 1'b0;
      m_req = 1'b0; m_type = '0; m_r1 = '0; m_r2 = '0; m_rob = '0; m_full = 1'b0;
    end else if (clear_in) begin
      foreach (m[i]) m[i].busy = 1'b0;
      m_req = 1'b0; m_full = 1'b0;
    end else if (rdy_in) begin
      sel = -1; free_slot = -1;
      for (int i = 0; i < RS_SIZE; i++) begin
        if (free_slot < 0 && !m[i].busy) free_slot = i;
        if (sel < 0 && m[i].busy) begin
          lookup(m[i].qj, jh, jv);
          lookup(m[i].qk, kh, kv);
          jr = !m[i].jw || (BYPASS && jh);
          kr = !m[i].kw || (BYPASS && kh);
          if (jr && kr) begin
            sel = i;
            m_type = m[i].op; m_rob = m[i].rob;
            m_r1 = m[i].jw ? jv : m[i].vj;
            m_r2 = m[i].kw ? kv : m[i].vk;
          end
        end
      end
      foreach (m[i]) if (m[i].busy) begin
        lookup(m[i].qj, jh, jv);
        lookup(m[i].qk, kh, kv);
        if (m[i].jw && jh) begin m[i].vj = jv; m[i].jw = 1'b0; end
        if (m[i].kw && kh) begin m[i].vk = kv; m[i].kw = 1'b0; end
      end
      m_req = (sel >= 0);
      if (sel >= 0) m[sel].busy = 1'b0;
      if (disp_valid && !m_full && free_slot >= 0) begin
        lookup(disp_qj, jh, jv);
        lookup(disp_qk, kh, kv);
        m[free_slot].busy = 1'b1;
        m[free_slot].op = disp_type; m[free_slot].rob = disp_rob_id;
        m[free_slot].qj = disp_qj;   m[free_slot].qk = disp_qk;
        m[free_slot].jw = disp_qj_busy && !jh;
        m[free_slot].kw = disp_qk_busy && !kh;
        m[free_slot].vj = (disp_qj_busy && jh) ? jv : disp_vj;
        m[free_slot].vk = (disp_qk_busy && kh) ? kv : disp_vk;
      end
      m_full = 1'b1;
      foreach (m[i]) m_full = m_full && m[i].busy;
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
  endtask

  task automatic idle();
    rst_in = 1'b0; clear_in = 1'b0; rdy_in = 1'b1; disp_valid = 1'b0;
    disp_type = '0; disp_rob_id = '0; disp_vj = '0; disp_vk = '0;
    disp_qj_busy = 1'b0; disp_qk_busy = 1'b0; disp_qj = '0; disp_qk = '0;
    alu_cdb_valid = 1'b0; alu_cdb_rob_id = '0; alu_cdb_value = '0;
    lsb_cdb_valid = 1'b0; lsb_cdb_rob_id = '0; lsb_cdb_value = '0;
  endtask

  task automatic set_disp(input logic [TB-1:0] t, input logic [RB-1:0] rob, input logic [31:0] vj,
                          input logic [31:0] vk, input logic qjb, input logic [RB-1:0] qj,
                          input logic qkb, input logic [RB-1:0] qk);
    disp_valid = 1'b1; disp_type = t; disp_rob_id = rob; disp_vj = vj; disp_vk = vk;
    disp_qj_busy = qjb; disp_qj = qj; disp_qk_busy = qkb; disp_qk = qk;
  endtask

  task automatic test_reset();
    idle();
    rst_in = 1'b1;
    cycle();
    cycle();
    rst_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_vec !== '0) $display("FAIL reset_outputs[%0d]: got %h want 0", k, dut_vec);
      else passed++;
      cycle();
    end
  endtask

  task automatic test_ready_issue();
    set_disp(6'h01, 4'd3, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0);
    cycle();
    idle();
    checks++;
    if (alu_req !== 1'b0) $display("FAIL add_early: alu_req got %b want 0", alu_req); else passed++;
    cycle();
    checks++;
    if ({alu_req, alu_r1, alu_r2, alu_rob_id} !== {1'b1, 32'd5, 32'd7, 4'd3})
      $display("FAIL add_issue: got req=%b r1=%0d r2=%0d rob=%0d want 1/5/7/3", alu_req, alu_r1, alu_r2, alu_rob_id);
    else passed++;
    cycle();
    checks++;
    if (alu_req !== 1'b0) $display("FAIL add_done: alu_req got %b want 0", alu_req); else passed++;
  endtask

  task automatic test_wakeup();
    bit ok;
    set_disp(6'h02, 4'd5, 32'hDEAD_BEEF, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0);
    cycle();
    idle();
    alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd2; alu_cdb_value = 32'd10;
    cycle();
    idle();
    for (int k = 0; k < 3; k++) begin
      if (k == WAKE_LAT) ok = ({alu_req, alu_r1, alu_r2, alu_rob_id} === {1'b1, 32'd10, 32'd1, 4'd5});
      else ok = (alu_req === 1'b0);
      checks++;
      if (!ok) $display("FAIL wakeup[%0d]: got req=%b r1=%0d r2=%0d rob=%0d", k, alu_req, alu_r1, alu_r2, alu_rob_id);
      else passed++;
      cycle();
    end
  endtask

  task automatic test_full();
    logic [RB-1:0] issued[$];
    for (int i = 0; i < RS_SIZE; i++) begin
      set_disp(6'h03, RB'(i), 32'h0, 32'(i), 1'b1, 4'd6, 1'b0, 4'd0);
      cycle();
    end
    idle();
    checks++;
    if ({full, alu_req} !== 2'b10) $display("FAIL full_set: got full=%b req=%b want 1/0", full, alu_req); else passed++;
    set_disp(6'h03, 4'd9, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0);
    cycle();
    idle();
    checks++;
    if (dut_vec !== m_vec()) $display("FAIL full_drop: got %h want %h", dut_vec, m_vec()); else passed++;
    lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 4'd6; lsb_cdb_value = 32'h20;
    cycle();
    idle();
    for (int k = 0; k < 10; k++) begin
      if (alu_req === 1'b1) begin
        if (issued.size() == 0) begin
          checks++;
          if (full !== 1'b0) $display("FAIL full_fall: got full=%b want 0", full); else passed++;
        end
        checks++;
        if (alu_r1 !== 32'h20) $display("FAIL full_r1[%0d]: got %h want 20", k, alu_r1); else passed++;
        issued.push_back(alu_rob_id);
      end
      checks++;
      if (dut_vec !== m_vec()) $display("FAIL full_drain[%0d]: got %h want %h", k, dut_vec, m_vec()); else passed++;
      cycle();
    end
    checks++;
    if (issued.size() != RS_SIZE) $display("FAIL full_count: got %0d want %0d", issued.size(), RS_SIZE);
    else passed++;
    foreach (issued[k]) begin
      checks++;
      if (issued[k] !== RB'(k)) $display("FAIL full_order[%0d]: got %0d want %0d", k, issued[k], k); else passed++;
    end
  endtask

  task automatic test_forward();
    set_disp(6'h04, 4'd8, 32'd3, 32'd0, 1'b0, 4'd0, 1'b1, 4'd4);
    lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 4'd4; lsb_cdb_value = 32'hFFFF_FFFF;
    cycle();
    idle();
    checks++;
    if (alu_req !== 1'b0) $display("FAIL fwd_early: alu_req got %b want 0", alu_req); else passed++;
    cycle();
    checks++;
    if ({alu_req, alu_r1, alu_r2, alu_rob_id} !== {1'b1, 32'd3, 32'hFFFF_FFFF, 4'd8})
      $display("FAIL fwd_issue: got req=%b r1=%h r2=%h rob=%0d", alu_req, alu_r1, alu_r2, alu_rob_id);
    else passed++;
    set_disp(6'h05, 4'd1, 32'd0, 32'd2, 1'b1, 4'd7, 1'b0, 4'd0);
    alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd7; alu_cdb_value = 32'h11;
    lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 4'd7; lsb_cdb_value = 32'h22;
    cycle();
    idle();
    cycle();
    checks++;
    if ({alu_req, alu_r1, alu_rob_id} !== {1'b1, 32'h11, 4'd1})
      $display("FAIL fwd_alu_wins: got req=%b r1=%h rob=%0d want 1/11/1", alu_req, alu_r1, alu_rob_id);
    else passed++;
    cycle();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) begin
      set_disp(6'h05, RB'(10 + i), 32'(i), 32'(i), 1'b0, 4'd0, 1'b0, 4'd0);
      cycle();
    end
    idle();
    set_disp(6'h05, 4'd15, 32'd9, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0);
    clear_in = 1'b1;
    cycle();
    idle();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({alu_req, full} !== 2'b00) $display("FAIL clear[%0d]: got req=%b full=%b want 0/0", k, alu_req, full);
      else passed++;
      cycle();
    end
  endtask

  task automatic test_rdy_hold();
    int consumed = 0;
    set_disp(6'h06, 4'hA, 32'h123, 32'h456, 1'b0, 4'd0, 1'b0, 4'd0);
    cycle();
    idle();
    cycle();
    rdy_in = 1'b0;
    set_disp(6'h07, 4'hB, 32'h1, 32'h2, 1'b0, 4'd0, 1'b0, 4'd0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({alu_req, alu_type, alu_r1, alu_r2, alu_rob_id, full} !== {1'b1, 6'h06, 32'h123, 32'h456, 4'hA, 1'b0})
        $display("FAIL hold[%0d]: got %h", k, dut_vec);
      else passed++;
      if (k < 3) cycle();
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      if (rdy_in && alu_req && alu_rob_id == 4'hA) consumed++;
      cycle();
      checks++;
      if (alu_req !== 1'b0) $display("FAIL hold_release[%0d]: alu_req got %b want 0", k, alu_req); else passed++;
    end
    checks++;
    if (consumed != 1) $display("FAIL hold_consume: got %0d want 1", consumed); else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      idle();
      rdy_in   = ($urandom_range(0, 9) != 0);
      clear_in = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 2) != 0)
        set_disp(TB'($urandom), RB'($urandom), $urandom, $urandom, 1'($urandom_range(0, 1)),
                 RB'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), RB'($urandom_range(0, 3)));
      alu_cdb_valid = 1'($urandom_range(0, 1)); alu_cdb_rob_id = RB'($urandom_range(0, 3)); alu_cdb_value = $urandom;
      lsb_cdb_valid = 1'($urandom_range(0, 1)); lsb_cdb_rob_id = RB'($urandom_range(0, 3)); lsb_cdb_value = $urandom;
      cycle();
      checks++;
      if (dut_vec !== m_vec()) $display("FAIL random[%0d]: got %h want %h", n, dut_vec, m_vec()); else passed++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ready_issue();
    test_wakeup();
    test_full();
    test_forward();
    test_clear();
    test_rdy_hold();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
